// File: rtl/router_scheduler.sv
// router_scheduler: layer sequencer pairing input-router contexts with weight-router passes into the systolic array.
// Define SCHED_PERF_CNT_EN to add the o_stall_count backpressure counter.
module router_scheduler #(
  parameter int ADDR_WIDTH = 8,
  parameter int SA_DEPTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_reg_clear,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_o_size,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  output logic                  o_ir_en,
  output logic                  o_ir_reg_clear,
  input  logic                  i_ir_ready,
  input  logic                  i_ir_context_done,
  input  logic                  i_ir_done,
  output logic                  o_ir_pop_en,
  output logic [ADDR_WIDTH-1:0] o_cfg_o_size,
  output logic [ADDR_WIDTH-1:0] o_cfg_stride,
  output logic                  o_wr_en,
  output logic                  o_wr_reuse,
  input  logic                  i_wr_ready,
  output logic                  o_wr_pop_en,
  input  logic                  i_sa_stall,
  output logic                  o_sa_valid,
  output logic                  o_sa_flush,
  output logic                  o_busy,
  output logic                  o_done,
`ifdef SCHED_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]  o_stall_count,
`endif
  output logic [CNT_WIDTH-1:0]  o_context_count
);
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_READY, STREAM, DRAIN, NEXT} state_t;
  localparam int DRAIN_W = $clog2(2 * SA_DEPTH) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(2 * SA_DEPTH - 1);
  state_t state_q;
  logic [DRAIN_W-1:0] drain_q;
  logic ir_en_q, ir_clr_q, wr_en_q, reuse_q, flush_q, done_q, fire;
  logic [ADDR_WIDTH-1:0] size_q, stride_q;
  logic [CNT_WIDTH-1:0] ctx_q;
`ifdef SCHED_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;
  assign o_stall_count = stall_q;
`endif
  // Pops follow the clear combinationally so none slips out on the clearing cycle.
  assign fire = (state_q == STREAM) && i_ir_ready && i_wr_ready && !i_sa_stall && !i_reg_clear;
  assign o_ir_pop_en = fire;
  assign o_wr_pop_en = fire;
  assign o_sa_valid = fire;
  assign o_busy = state_q != IDLE;
  assign o_ir_en = ir_en_q;
  assign o_ir_reg_clear = ir_clr_q;
  assign o_wr_en = wr_en_q;
  assign o_wr_reuse = reuse_q;
  assign o_sa_flush = flush_q;
  assign o_done = done_q;
  assign o_context_count = ctx_q;
  assign o_cfg_o_size = size_q;
  assign o_cfg_stride = stride_q;
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE; drain_q <= '0; ctx_q <= '0; size_q <= '0; stride_q <= '0;
      ir_en_q <= 1'b0; ir_clr_q <= 1'b0; wr_en_q <= 1'b0; reuse_q <= 1'b0; flush_q <= 1'b0; done_q <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
      stall_q <= '0;
`endif
    end else if (i_reg_clear) begin
      state_q <= IDLE; drain_q <= '0; ctx_q <= '0; size_q <= '0; stride_q <= '0;
      ir_en_q <= 1'b0; ir_clr_q <= 1'b0; wr_en_q <= 1'b0; reuse_q <= 1'b0; flush_q <= 1'b0; done_q <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      ir_clr_q <= 1'b0;
      reuse_q <= 1'b0;
      flush_q <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          state_q <= CLEAR; size_q <= i_o_size; stride_q <= i_stride;
          done_q <= 1'b0; ctx_q <= '0; ir_clr_q <= 1'b1;
`ifdef SCHED_PERF_CNT_EN
          stall_q <= '0;
`endif
        end
        CLEAR: begin
          state_q <= WAIT_READY; ir_en_q <= 1'b1; wr_en_q <= 1'b1;
        end
        WAIT_READY: if (i_ir_ready && i_wr_ready) state_q <= STREAM;
        STREAM: if (!i_ir_ready) begin
          state_q <= DRAIN; drain_q <= DRAIN_LOAD;
        end
        DRAIN: begin
          drain_q <= drain_q - 1'b1;
          if (drain_q == DRAIN_W'(1)) begin
            state_q <= NEXT; flush_q <= 1'b1;
            ctx_q <= (&ctx_q) ? ctx_q : ctx_q + 1'b1;
          end
        end
        NEXT: if (i_ir_done) begin
          state_q <= IDLE; done_q <= 1'b1; ir_en_q <= 1'b0; wr_en_q <= 1'b0;
        end else if (i_ir_context_done) begin
          state_q <= WAIT_READY; reuse_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
`ifdef SCHED_PERF_CNT_EN
      if (state_q == STREAM && i_ir_ready && !fire && !(&stall_q)) stall_q <= stall_q + 1'b1;
`endif
    end
  end
endmodule
